// File: rtl/cpu_decode_pkg.sv
// Shared decode definitions: form encodings, long-immediate opcode set,
// legality bounds and instruction lengths.
package cpu_defs;

  typedef enum logic [1:0] {
    FORM1 = 2'd0,
    FORM2 = 2'd2,
    FORM3 = 2'd3
  } form_e;

  localparam logic [7:0] OP_LONG_01 = 8'h01;
  localparam logic [7:0] OP_LONG_03 = 8'h03;
  localparam logic [7:0] OP_LONG_08 = 8'h08;
  localparam logic [7:0] OP_LONG_09 = 8'h09;
  localparam logic [7:0] OP_LONG_0C = 8'h0c;
  localparam logic [7:0] OP_LONG_0D = 8'h0d;
  localparam logic [7:0] OP_LONG_1A = 8'h1a;
  localparam logic [7:0] OP_LONG_1B = 8'h1b;
  localparam logic [7:0] OP_LONG_1D = 8'h1d;
  localparam logic [7:0] OP_LONG_1F = 8'h1f;
  localparam logic [7:0] OP_LONG_20 = 8'h20;
  localparam logic [7:0] OP_LONG_22 = 8'h22;
  localparam logic [7:0] OP_LONG_24 = 8'h24;
  localparam logic [7:0] OP_LONG_30 = 8'h30;
  localparam logic [7:0] OP_LONG_36 = 8'h36;
  localparam logic [7:0] OP_LONG_37 = 8'h37;
  localparam logic [7:0] OP_LONG_38 = 8'h38;
  localparam logic [7:0] OP_LONG_39 = 8'h39;

  localparam logic [7:0]  MAX_FORM1_OP = 8'h39;
  localparam logic [3:0]  MAX_COND     = 4'd9;
  localparam logic [31:0] LEN_SHORT    = 32'd2;
  localparam logic [31:0] LEN_LONG     = 32'd6;

  typedef struct packed {
    form_e       form;
    logic [7:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic        len6;
    logic        illegal;
  } dec_t;

  function automatic logic is_long(input logic [7:0] op);
    case (op)
      OP_LONG_01, OP_LONG_03, OP_LONG_08, OP_LONG_09, OP_LONG_0C, OP_LONG_0D,
      OP_LONG_1A, OP_LONG_1B, OP_LONG_1D, OP_LONG_1F, OP_LONG_20, OP_LONG_22,
      OP_LONG_24, OP_LONG_30, OP_LONG_36, OP_LONG_37, OP_LONG_38, OP_LONG_39:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode_classify.sv
// Combinational classifier: opcode, trailing operand and current pc to
// decoded fields, length and immediate/branch target.
module cpu_decode_classify
  import cpu_defs::*;
(
  input  logic [15:0] opcode,
  input  logic [31:0] operand,
  input  logic [31:0] pc,
  output dec_t        dec
);

  logic [31:0] br_off;

  // 10-bit halfword offset, sign-extended and scaled to bytes
  assign br_off = {{21{opcode[9]}}, opcode[9:0], 1'b0};

  always_comb begin
    dec = '0;
    if (!opcode[15]) begin
      dec.form    = FORM1;
      dec.op      = opcode[15:8];
      dec.ra      = opcode[7:4];
      dec.rb      = opcode[3:0];
      dec.len6    = is_long(opcode[15:8]);
      dec.imm     = dec.len6 ? operand : 32'd0;
      dec.illegal = (opcode[15:8] == 8'h00) || (opcode[15:8] > MAX_FORM1_OP);
    end else if (!opcode[14]) begin
      dec.form = FORM2;
      dec.op   = {6'd0, opcode[13:12]};
      dec.ra   = opcode[11:8];
      dec.imm  = {24'd0, opcode[7:0]};
    end else begin
      dec.form    = FORM3;
      dec.op      = {4'd0, opcode[13:10]};
      dec.imm     = pc + LEN_SHORT + br_off;
      dec.illegal = opcode[13:10] > MAX_COND;
    end
  end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: single registered slot into execute plus the running pc,
// honouring the shared interlock and branch flush.
module cpu_decode
  import cpu_defs::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] opcode_i,
  input  logic [31:0] operand_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        valid_o,
  output logic [1:0]  form_o,
  output logic [7:0]  op_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic        len6_o,
  output logic        illegal_o
);

  dec_t        dec, dec_q;
  logic [31:0] pc_q, pc_out_q;
  logic        vld_q;

  cpu_decode_classify u_classify (
    .opcode  (opcode_i),
    .operand (operand_i),
    .pc      (pc_q),
    .dec     (dec)
  );

  // flush beats stall; a flushed slot keeps its stale fields, only valid drops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= 1'b0;
      pc_q     <= BOOT_ADDRESS;
      pc_out_q <= BOOT_ADDRESS;
      dec_q    <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
      pc_q  <= branch_target_i;
    end else if (!stall_i) begin
      if (valid_i) begin
        vld_q    <= 1'b1;
        dec_q    <= dec;
        pc_out_q <= pc_q;
        pc_q     <= pc_q + (dec.len6 ? LEN_LONG : LEN_SHORT);
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign valid_o   = vld_q;
  assign form_o    = dec_q.form;
  assign op_o      = dec_q.op;
  assign ra_o      = dec_q.ra;
  assign rb_o      = dec_q.rb;
  assign imm_o     = dec_q.imm;
  assign pc_o      = pc_out_q;
  assign len6_o    = dec_q.len6;
  assign illegal_o = dec_q.illegal;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed bench for cpu_decode: behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_cpu_decode;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, stall_i, flush_i;
  logic [15:0] opcode_i;
  logic [31:0] operand_i, branch_target_i;
  logic        valid_o, len6_o, illegal_o;
  logic [1:0]  form_o;
  logic [7:0]  op_o;
  logic [3:0]  ra_o, rb_o;
  logic [31:0] imm_o, pc_o;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  always #5 clk = ~clk;

  cpu_decode #(.BOOT_ADDRESS(32'h00001000)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .branch_target_i(branch_target_i), .valid_o(valid_o), .form_o(form_o),
    .op_o(op_o), .ra_o(ra_o), .rb_o(rb_o), .imm_o(imm_o), .pc_o(pc_o),
    .len6_o(len6_o), .illegal_o(illegal_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned long_ops[18] = '{'h01, 'h03, 'h08, 'h09, 'h0c, 'h0d, 'h1a, 'h1b, 'h1d,
                                'h1f, 'h20, 'h22, 'h24, 'h30, 'h36, 'h37, 'h38, 'h39};
  int unsigned m_pc, m_pc_o, m_imm, m_form, m_op, m_ra, m_rb;
  bit m_valid, m_len6, m_ill;

  always @(posedge clk) begin
    int unsigned f, o, cnd, byte1;
    int off;
    bit lng;
    if (rst_i) begin
      m_valid <= 0; m_pc <= 32'h1000; m_pc_o <= 32'h1000;
      m_imm <= 0; m_form <= 0; m_op <= 0; m_ra <= 0; m_rb <= 0; m_len6 <= 0; m_ill <= 0;
    end else if (flush_i) begin
      m_valid <= 0; m_pc <= branch_target_i;
    end else if (!stall_i && valid_i) begin
      byte1 = opcode_i / 256;
      f = (opcode_i < 16'h8000) ? 0 : ((opcode_i < 16'hC000) ? 2 : 3);
      lng = 0;
      foreach (long_ops[i]) if (f == 0 && long_ops[i] == byte1) lng = 1;
      m_valid <= 1; m_form <= f; m_len6 <= lng; m_pc_o <= m_pc;
      m_pc <= m_pc + (lng ? 6 : 2);
      if (f == 0) begin
        m_op <= byte1; m_ra <= (opcode_i / 16) % 16; m_rb <= opcode_i % 16;
        m_imm <= lng ? operand_i : 0;
        m_ill <= (byte1 == 0) || (byte1 > 57);
      end else if (f == 2) begin
        m_op <= (opcode_i / 4096) % 4; m_ra <= byte1 % 16; m_rb <= 0;
        m_imm <= opcode_i % 256; m_ill <= 0;
      end else begin
        cnd = (opcode_i / 1024) % 16;
        o = opcode_i % 1024;
        off = (o >= 512) ? int'(o) - 1024 : int'(o);
        m_op <= cnd; m_ra <= 0; m_rb <= 0; m_ill <= cnd > 9;
        m_imm <= m_pc + 2 + 2 * off;
      end
    end else if (!stall_i) begin
      m_valid <= 0;
    end
    model_live <= 1'b1;
  end

  // compare process: every cycle once the model has been reset
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("m_valid", {31'd0, valid_o}, {31'd0, m_valid});
        chk("m_pc_o", pc_o, m_pc_o);
        chk("m_form", {30'd0, form_o}, m_form);
        chk("m_op", {24'd0, op_o}, m_op);
        chk("m_ra", {28'd0, ra_o}, m_ra);
        chk("m_rb", {28'd0, rb_o}, m_rb);
        chk("m_imm", imm_o, m_imm);
        chk("m_len6", {31'd0, len6_o}, {31'd0, m_len6});
        chk("m_illegal", {31'd0, illegal_o}, {31'd0, m_ill});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic r, input logic v, input logic [15:0] op, input logic [31:0] opnd,
                       input logic st, input logic fl, input logic [31:0] tgt);
    rst_i = r; valid_i = v; opcode_i = op; operand_i = opnd;
    stall_i = st; flush_i = fl; branch_target_i = tgt;
    @(posedge clk); #1;
  endtask

  task automatic acc(input logic [15:0] op, input logic [31:0] opnd);
    drive(0, 1, op, opnd, 0, 0, 32'd0);
  endtask

  initial begin
    rst_i = 1; valid_i = 0; opcode_i = 0; operand_i = 0;
    stall_i = 0; flush_i = 0; branch_target_i = 0;
    drive(1, 0, 16'h0, 0, 0, 0, 0);
    drive(1, 1, 16'h0123, 32'h55, 0, 0, 0);
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_pc_o", pc_o, 32'h1000);
    chk("rst_imm", imm_o, 0);

    acc(16'h0123, 32'hDEADBEEF);
    chk("f1_valid", {31'd0, valid_o}, 1);
    chk("f1_op", {24'd0, op_o}, 32'h01);
    chk("f1_ra_rb", {24'd0, ra_o, rb_o}, 32'h23);
    chk("f1_imm", imm_o, 32'hDEADBEEF);
    chk("f1_pc", pc_o, 32'h1000);
    chk("f1_len6", {31'd0, len6_o}, 1);
    acc(16'h0500, 32'hFFFF0000);
    chk("after_long_pc", pc_o, 32'h1006);
    chk("short_imm", imm_o, 0);

    drive(0, 1, 16'h0500, 0, 0, 1, 32'h2000);
    chk("flush_valid", {31'd0, valid_o}, 0);
    acc(16'hC3FE, 0);
    chk("br_pc", pc_o, 32'h2000);
    chk("br_imm", imm_o, 32'h1FFE);
    chk("br_form", {30'd0, form_o}, 3);
    acc(16'h8A7F, 0);
    chk("f2_ra", {28'd0, ra_o}, 32'hA);
    chk("f2_imm", imm_o, 32'h7F);
    chk("f2_pc", pc_o, 32'h2002);
    acc(16'h0240, 0);
    chk("pre_stall_pc", pc_o, 32'h2004);

    for (int i = 0; i < 3; i++) begin
      drive(0, i[0], 16'h0340 + 16'(i), 32'h12345678, 1, 0, 0);
      chk("stall_valid", {31'd0, valid_o}, 1);
      chk("stall_pc", pc_o, 32'h2004);
      chk("stall_op", {24'd0, op_o}, 32'h02);
    end
    acc(16'h0340, 32'h12345678);
    chk("resume_pc", pc_o, 32'h2006);
    chk("resume_imm", imm_o, 32'h12345678);
    acc(16'h0450, 0);
    chk("resume2_pc", pc_o, 32'h200C);
    drive(0, 0, 16'h0500, 0, 0, 0, 0);
    chk("bubble_valid", {31'd0, valid_o}, 0);
    acc(16'h0500, 0);
    chk("post_bubble_pc", pc_o, 32'h200E);

    drive(0, 1, 16'h0500, 0, 1, 1, 32'h4000);
    chk("flush_stall_valid", {31'd0, valid_o}, 0);
    acc(16'h0000, 0);
    chk("flush_target_pc", pc_o, 32'h4000);
    chk("ill_op0", {31'd0, illegal_o}, 1);
    acc(16'h3A00, 0);
    chk("ill_3a", {31'd0, illegal_o}, 1);
    chk("ill_3a_pc", pc_o, 32'h4002);
    acc(16'hF000, 0);
    chk("ill_cond12", {31'd0, illegal_o}, 1);
    chk("ill_cond12_pc", pc_o, 32'h4004);
    acc(16'h0500, 0);
    chk("post_ill_pc", pc_o, 32'h4006);
    chk("legal_again", {31'd0, illegal_o}, 0);

    drive(0, 0, 16'h0, 0, 0, 1, 32'hFFFFFFFE);
    acc(16'h0500, 0);
    chk("wrap_pc0", pc_o, 32'hFFFFFFFE);
    acc(16'h0500, 0);
    chk("wrap_pc1", pc_o, 32'h0);

    drive(0, 1, 16'h0500, 0, 1, 0, 0);
    drive(1, 1, 16'h0500, 0, 1, 1, 32'h8000);
    chk("mid_stall_rst_valid", {31'd0, valid_o}, 0);
    chk("mid_stall_rst_pc", pc_o, 32'h1000);
    acc(16'h0500, 0);
    chk("post_rst_pc", pc_o, 32'h1000);

    for (int i = 0; i < 60; i++) begin
      drive(0, 1'($urandom_range(0, 3) != 0), 16'($urandom), $urandom,
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            $urandom & 32'hFFFFFFFE);
    end
    drive(0, 0, 16'h0, 0, 0, 0, 0);

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
